// File: rtl/md_issue_ctrl_if.sv
// D-stage / MD-unit signal bundle for the multiply/divide issue controller.
// The controller connects through the slave modport; the environment uses master.
interface md_issue_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_rs_val;
  logic [XLEN-1:0] d_rt_val;
  logic            ext_stall;
  logic            md_busy_in;
  logic            md_start;
  logic [OP_W-1:0] md_op;
  logic [XLEN-1:0] md_a;
  logic [XLEN-1:0] md_b;
  logic            md_stall;
  logic            err;

  modport master (
    output d_instr, d_rs_val, d_rt_val, ext_stall, md_busy_in,
    input  md_start, md_op, md_a, md_b, md_stall, err
  );

  modport slave (
    input  d_instr, d_rs_val, d_rt_val, ext_stall, md_busy_in,
    output md_start, md_op, md_a, md_b, md_stall, err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue-side controller for the multi-cycle MD unit: decodes D, issues ops,
// tracks latency locally, stalls colliding MD-class instructions, flags busy mismatches.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_issue_if.slave bus
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              err_q, err_d;

  logic              is_md;
  logic              is_muldiv;
  logic              is_mtx;
  logic [OP_W-1:0]   dec_op;
  logic              md_stall_c;
  logic              accept;
  logic              busy_idle_err;
  logic              busy_lost_err;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^bus.d_instr[25:6];

  // Decode: only SPECIAL-opcode MD functs are of interest; mfhi/mflo are MD-class without an op.
  always_comb begin
    is_md  = 1'b0;
    dec_op = OP_NONE;
    if (bus.d_instr[31:26] == 6'd0) begin
      case (bus.d_instr[5:0])
        6'h18:        begin is_md = 1'b1; dec_op = OP_MULT;  end
        6'h19:        begin is_md = 1'b1; dec_op = OP_MULTU; end
        6'h1A:        begin is_md = 1'b1; dec_op = OP_DIV;   end
        6'h1B:        begin is_md = 1'b1; dec_op = OP_DIVU;  end
        6'h11:        begin is_md = 1'b1; dec_op = OP_MTHI;  end
        6'h13:        begin is_md = 1'b1; dec_op = OP_MTLO;  end
        6'h10, 6'h12: is_md = 1'b1;
        default:      is_md = 1'b0;
      endcase
    end
  end

  assign is_muldiv  = (dec_op >= OP_MULT) && (dec_op <= OP_DIVU);
  assign is_mtx     = (dec_op == OP_MTHI) || (dec_op == OP_MTLO);
  assign md_stall_c = (state_q == BUSY) && is_md;
  assign accept     = is_md && !md_stall_c && !bus.ext_stall;

  assign busy_idle_err = bus.md_busy_in && (state_q == IDLE) && !start_q;
  assign busy_lost_err = !bus.md_busy_in && (state_q == BUSY) && (cnt_q != '0) && !start_q;

  // Next state: counter runs regardless of ext_stall; a load only ever happens from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    op_d    = OP_NONE;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q || busy_idle_err || busy_lost_err;

    if (state_q == BUSY) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end

    if (accept) begin
      if (is_muldiv) begin
        start_d = 1'b1;
        op_d    = dec_op;
        a_d     = bus.d_rs_val;
        b_d     = bus.d_rt_val;
        state_d = BUSY;
        cnt_d   = ((dec_op == OP_MULT) || (dec_op == OP_MULTU)) ? CNT_W'(MULT_LAT)
                                                                 : CNT_W'(DIV_LAT);
      end else if (is_mtx) begin
        op_d = dec_op;
        a_d  = bus.d_rs_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign bus.md_start = start_q;
  assign bus.md_op    = op_q;
  assign bus.md_a     = a_q;
  assign bus.md_b     = b_q;
  assign bus.md_stall = md_stall_c;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a simple MD-unit busy model.
module tb_md_issue_ctrl;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  localparam logic [31:0] I_MULT  = 32'h00850018;
  localparam logic [31:0] I_MULTU = 32'h00850019;
  localparam logic [31:0] I_DIV   = 32'h0085001A;
  localparam logic [31:0] I_MTHI  = 32'h00800011;
  localparam logic [31:0] I_MFLO  = 32'h00001012;
  localparam logic [31:0] I_ADDU  = 32'h00851021;

  logic clk = 1'b0;
  logic reset;
  logic force_busy;
  int unsigned busy_rem;
  int total = 0;
  int bad   = 0;
  int n;
  int starts;

  always #5 clk = ~clk;

  md_issue_if bus ();

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // MD unit: busy from the cycle after start until LAT-1 further edges have passed.
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_rem <= 0;
    else if (bus.md_start)
      busy_rem <= ((bus.md_op == 4'd1 || bus.md_op == 4'd2) ? MULT_LAT : DIV_LAT) - 1;
    else if (busy_rem != 0) busy_rem <= busy_rem - 1;
  end

  assign bus.md_busy_in = (busy_rem != 0) || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    bus.d_instr  = instr;
    bus.d_rs_val = rs;
    bus.d_rt_val = rt;
  endtask

  initial begin
    reset         = 1'b0;
    force_busy    = 1'b0;
    bus.ext_stall = 1'b0;
    drive(32'h0, 32'h0, 32'h0);
    #12;
    chk("rst_start", 32'(bus.md_start), 32'd0);
    chk("rst_op",    32'(bus.md_op),    32'd0);
    chk("rst_a",     bus.md_a,          32'd0);
    chk("rst_b",     bus.md_b,          32'd0);
    chk("rst_err",   32'(bus.err),      32'd0);
    chk("rst_stall", 32'(bus.md_stall), 32'd0);
    reset = 1'b1;
    tick();

    // 1: mult from IDLE, BUSY for MULT_LAT+1 cycles
    drive(I_MULT, 32'd7, 32'hFFFF_FFFD);
    #1 chk("t1_no_stall", 32'(bus.md_stall), 32'd0);
    tick();
    chk("t1_start", 32'(bus.md_start), 32'd1);
    chk("t1_op",    32'(bus.md_op),    32'd1);
    chk("t1_a",     bus.md_a,          32'd7);
    chk("t1_b",     bus.md_b,          32'hFFFF_FFFD);
    drive(I_MFLO, 32'd0, 32'd0);
    #1;
    n = 0;
    while (bus.md_stall && n < 40) begin n++; tick(); end
    chk("t1_busy_cycles", 32'(n), 32'd6);
    chk("t1_start_drop", 32'(bus.md_start), 32'd0);
    chk("t1_op_drop",    32'(bus.md_op),    32'd0);
    chk("t1_a_hold",     bus.md_a,          32'd7);
    tick();
    drive(32'h0, 32'h0, 32'h0);

    // 2: div, non-MD flows during BUSY, mflo stalls 11 cycles
    drive(I_DIV, 32'd100, 32'd7);
    #1 tick();
    chk("t2_start", 32'(bus.md_start), 32'd1);
    chk("t2_op",    32'(bus.md_op),    32'd3);
    drive(I_ADDU, 32'd1, 32'd2);
    #1 chk("t2_nonmd_flows", 32'(bus.md_stall), 32'd0);
    drive(I_MFLO, 32'd0, 32'd0);
    #1;
    n = 0;
    while (bus.md_stall && n < 40) begin n++; tick(); end
    chk("t2_stall_cycles", 32'(n), 32'd11);
    tick();
    drive(32'h0, 32'h0, 32'h0);

    // 3: mthi in IDLE
    drive(I_MTHI, 32'h1234, 32'hDEAD);
    #1 chk("t3_no_stall", 32'(bus.md_stall), 32'd0);
    tick();
    drive(32'h0, 32'h0, 32'h0);
    chk("t3_op",    32'(bus.md_op),    32'd5);
    chk("t3_a",     bus.md_a,          32'h1234);
    chk("t3_start", 32'(bus.md_start), 32'd0);
    chk("t3_b_hold", bus.md_b,         32'd7);
    tick();
    chk("t3_op_drop", 32'(bus.md_op), 32'd0);
    chk("t3_a_hold",  bus.md_a,       32'h1234);

    // 4: mult held by ext_stall for 3 cycles, then exactly one start
    drive(I_MULT, 32'd3, 32'd9);
    bus.ext_stall = 1'b1;
    starts = 0;
    repeat (3) begin tick(); if (bus.md_start) starts++; end
    chk("t4_held", 32'(starts), 32'd0);
    bus.ext_stall = 1'b0;
    tick();
    drive(32'h0, 32'h0, 32'h0);
    chk("t4_start", 32'(bus.md_start), 32'd1);
    chk("t4_a",     bus.md_a,          32'd3);
    chk("t4_b",     bus.md_b,          32'd9);
    starts = 0;
    repeat (8) begin tick(); if (bus.md_start) starts++; end
    chk("t4_once", 32'(starts), 32'd0);
    chk("t4_err",  32'(bus.err), 32'd0);

    // 5: reset while a div has cnt==4, then multu issues normally
    drive(I_DIV, 32'd50, 32'd5);
    #1 tick();
    drive(I_MFLO, 32'd0, 32'd0);
    chk("t5_start", 32'(bus.md_start), 32'd1);
    repeat (6) tick();
    #1 chk("t5_pre_stall", 32'(bus.md_stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_stall", 32'(bus.md_stall), 32'd0);
    chk("t5_rst_start", 32'(bus.md_start), 32'd0);
    chk("t5_rst_op",    32'(bus.md_op),    32'd0);
    chk("t5_rst_a",     bus.md_a,          32'd0);
    tick();
    reset = 1'b1;
    drive(I_MULTU, 32'hA, 32'hB);
    #1 chk("t5_no_stall", 32'(bus.md_stall), 32'd0);
    tick();
    drive(32'h0, 32'h0, 32'h0);
    chk("t5_start2", 32'(bus.md_start), 32'd1);
    chk("t5_op2",    32'(bus.md_op),    32'd2);
    chk("t5_a2",     bus.md_a,          32'hA);
    chk("t5_b2",     bus.md_b,          32'hB);
    repeat (8) tick();
    chk("t5_err", 32'(bus.err), 32'd0);

    // 6: spurious busy while IDLE sets sticky err
    force_busy = 1'b1;
    #1 tick();
    force_busy = 1'b0;
    chk("t6_err_set", 32'(bus.err), 32'd1);
    drive(I_MTHI, 32'h55, 32'h0);
    tick();
    drive(I_MULT, 32'd2, 32'd3);
    tick();
    drive(32'h0, 32'h0, 32'h0);
    repeat (8) tick();
    chk("t6_err_sticky", 32'(bus.err), 32'd1);
    reset = 1'b0;
    #1 chk("t6_err_clr", 32'(bus.err), 32'd0);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
